// File: rtl/sdr_ref_ctrl.sv
// sdr_ref_ctrl: SDRAM auto-refresh credit tracker (interval timer + pending-credit counter).
// Latency: credit visible on ref_pending the edge after the timer expires; refresh_req/ref_urgent are combinational decodes of it.
// Backpressure: none; credits accumulate up to MAX_PEND, a credit arriving at saturation sets sticky ref_overflow.
//
// Ports:
//   sdram_clk    - sole clock, rising edge
//   sdram_rst_n  - synchronous active-low reset
//   ref_en       - enables the refresh interval timer
//   cmd_aref     - one-cycle auto-refresh acknowledge from the command FSM
//   state_idle   - command FSM idle (postpone build only)
//   fifo_empty   - ingress command FIFO empty (postpone build only)
//   refresh_req  - request to issue auto-refresh
//   ref_urgent   - pending credits at MAX_PEND
//   ref_pending  - registered outstanding credit count
//   ref_overflow - sticky: a credit was lost at saturation
//
// Build option: define SDR_REF_POSTPONE_EN to defer refresh while traffic is
// queued, unless credits reach LAZY_THR.
module sdr_ref_ctrl #(
    parameter int REF_INTERVAL = 780,
    parameter int MAX_PEND     = 8,
    parameter int LAZY_THR     = 4
) (
    input  logic       sdram_clk,
    input  logic       sdram_rst_n,
    input  logic       ref_en,
    input  logic       cmd_aref,
    input  logic       state_idle,
    input  logic       fifo_empty,
    output logic       refresh_req,
    output logic       ref_urgent,
    output logic [3:0] ref_pending,
    output logic       ref_overflow
);
    localparam logic [15:0] RELOAD   = 16'(REF_INTERVAL - 1);
    localparam logic [3:0]  PEND_MAX = 4'(MAX_PEND);

    logic [15:0] timer;
    logic [3:0]  pending;
    logic        overflow;
    logic        tick;

    // Timer expiry and reload happen on the same edge, so ticks are
    // exactly REF_INTERVAL cycles apart.
    assign tick = ref_en && (timer == 16'd0);

    always_ff @(posedge sdram_clk) begin
        if (!sdram_rst_n) begin
            timer <= RELOAD;
        end else if (!ref_en || tick) begin
            timer <= RELOAD;
        end else begin
            timer <= timer - 16'd1;
        end
    end

    // A tick and an acknowledge on the same edge cancel out; an ack with
    // nothing pending (init-sequence refreshes) is simply ignored.
    always_ff @(posedge sdram_clk) begin
        if (!sdram_rst_n) begin
            pending  <= 4'd0;
            overflow <= 1'b0;
        end else if (tick && !cmd_aref) begin
            if (pending == PEND_MAX) begin
                overflow <= 1'b1;
            end else begin
                pending <= pending + 4'd1;
            end
        end else if (cmd_aref && !tick && (pending != 4'd0)) begin
            pending <= pending - 4'd1;
        end
    end

    assign ref_pending  = pending;
    assign ref_overflow = overflow;
    assign ref_urgent   = (pending == PEND_MAX);

`ifdef SDR_REF_POSTPONE_EN
    localparam logic [3:0] LAZY_C = 4'(LAZY_THR);

    assign refresh_req = (pending >= LAZY_C)
                       || ((pending != 4'd0) && state_idle && fifo_empty);
`else
    // Idle/FIFO status and LAZY_THR only matter when postponing.
    logic unused_ok;
    assign unused_ok   = &{1'b0, state_idle, fifo_empty, (LAZY_THR > 0)};
    assign refresh_req = (pending != 4'd0);
`endif

endmodule

// File: tb/tb_sdr_ref_ctrl.sv
module tb_sdr_ref_ctrl;
    localparam int RI  = 16;
    localparam int MP  = 8;
    localparam int LT  = 4;

    logic       sdram_clk = 1'b0;
    logic       sdram_rst_n = 1'b0;
    logic       ref_en = 1'b0;
    logic       cmd_aref = 1'b0;
    logic       state_idle = 1'b0;
    logic       fifo_empty = 1'b0;
    logic       refresh_req;
    logic       ref_urgent;
    logic [3:0] ref_pending;
    logic       ref_overflow;

    sdr_ref_ctrl #(.REF_INTERVAL(RI), .MAX_PEND(MP), .LAZY_THR(LT)) dut (
        .sdram_clk   (sdram_clk),
        .sdram_rst_n (sdram_rst_n),
        .ref_en      (ref_en),
        .cmd_aref    (cmd_aref),
        .state_idle  (state_idle),
        .fifo_empty  (fifo_empty),
        .refresh_req (refresh_req),
        .ref_urgent  (ref_urgent),
        .ref_pending (ref_pending),
        .ref_overflow(ref_overflow)
    );

    always #5 sdram_clk = ~sdram_clk;

    typedef struct {
        logic [3:0] pend;
        logic       req;
        logic       urg;
        logic       ovf;
    } exp_t;

    exp_t sb_q[$];
    exp_t e;
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference model state
    int m_timer = RI - 1;
    int m_pend  = 0;
    logic m_ovf = 1'b0;

    function automatic logic model_req(input int p);
`ifdef SDR_REF_POSTPONE_EN
        return (p >= LT) || ((p != 0) && state_idle && fifo_empty);
`else
        return (p != 0);
`endif
    endfunction

    // Drive one cycle of stimulus, push the model's expectation for the
    // state after the edge, then advance to just past that edge.
    task automatic drive_cycle(input logic rst_v, input logic en_v, input logic ack_v);
        logic tk;
        exp_t x;
        sdram_rst_n = rst_v;
        ref_en      = en_v;
        cmd_aref    = ack_v;
        tk = en_v && (m_timer == 0);
        if (!rst_v) begin
            m_timer = RI - 1;
            m_pend  = 0;
            m_ovf   = 1'b0;
        end else begin
            if (!en_v || m_timer == 0) m_timer = RI - 1;
            else m_timer = m_timer - 1;
            if (tk && !ack_v) begin
                if (m_pend == MP) m_ovf = 1'b1;
                else m_pend = m_pend + 1;
            end else if (ack_v && !tk && m_pend != 0) begin
                m_pend = m_pend - 1;
            end
        end
        x.pend = 4'(m_pend);
        x.urg  = (m_pend == MP);
        x.ovf  = m_ovf;
        x.req  = model_req(m_pend);
        sb_q.push_back(x);
        @(posedge sdram_clk);
        #1;
    endtask

    task automatic test_reset();
        for (int c = 0; c < 3; c++) begin
            drive_cycle(1'b0, 1'b1, 1'b1);
            e = sb_q.pop_front();
            n_cmp++;
            if ({ref_pending, refresh_req, ref_urgent, ref_overflow} !== {4'd0, 1'b0, 1'b0, 1'b0}) begin
                n_err++;
                $display("FAIL reset cyc%0d: got pend=%0d req=%b urg=%b ovf=%b, need all 0",
                         c, ref_pending, refresh_req, ref_urgent, ref_overflow);
            end
        end
    endtask

    task automatic test_tick_timing();
        drive_cycle(1'b0, 1'b1, 1'b0);
        void'(sb_q.pop_front());
        for (int c = 1; c <= 32; c++) begin
            drive_cycle(1'b1, 1'b1, 1'b0);
            e = sb_q.pop_front();
            n_cmp++;
            if ({ref_pending, refresh_req, ref_urgent, ref_overflow} !== {e.pend, e.req, e.urg, e.ovf}) begin
                n_err++;
                $display("FAIL timing edge%0d: got pend=%0d req=%b urg=%b ovf=%b, need pend=%0d req=%b urg=%b ovf=%b",
                         c, ref_pending, refresh_req, ref_urgent, ref_overflow, e.pend, e.req, e.urg, e.ovf);
            end
            if (c == 15 || c == 16 || c == 32) begin
                n_cmp++;
                if (ref_pending !== ((c == 15) ? 4'd0 : (c == 16) ? 4'd1 : 4'd2)
                    || refresh_req !== (c != 15)) begin
                    n_err++;
                    $display("FAIL first_tick edge%0d: got pend=%0d req=%b", c, ref_pending, refresh_req);
                end
            end
        end
    endtask

    task automatic test_ack_each();
        int  age;
        logic ack;
        drive_cycle(1'b0, 1'b1, 1'b0);
        void'(sb_q.pop_front());
        age = -1;
        for (int c = 1; c <= 70; c++) begin
            ack = (age == 2);
            drive_cycle(1'b1, 1'b1, ack);
            e = sb_q.pop_front();
            n_cmp++;
            if ({ref_pending, refresh_req, ref_urgent, ref_overflow} !== {e.pend, e.req, e.urg, e.ovf}) begin
                n_err++;
                $display("FAIL ack_each edge%0d: got pend=%0d req=%b urg=%b ovf=%b, need pend=%0d req=%b urg=%b ovf=%b",
                         c, ref_pending, refresh_req, ref_urgent, ref_overflow, e.pend, e.req, e.urg, e.ovf);
            end
            if (ack) begin
                n_cmp++;
                if (ref_pending !== 4'd0 || refresh_req !== 1'b0 || ref_overflow !== 1'b0) begin
                    n_err++;
                    $display("FAIL ack_drop edge%0d: got pend=%0d req=%b ovf=%b, need 0/0/0",
                             c, ref_pending, refresh_req, ref_overflow);
                end
            end
            if (e.pend == 4'd1 && age < 0) age = 0;
            else if (age >= 0) age++;
            if (ack) age = -1;
        end
    endtask

    task automatic test_saturate();
        drive_cycle(1'b0, 1'b1, 1'b0);
        void'(sb_q.pop_front());
        for (int c = 1; c <= 150; c++) begin
            drive_cycle(1'b1, 1'b1, 1'b0);
            e = sb_q.pop_front();
            n_cmp++;
            if ({ref_pending, refresh_req, ref_urgent, ref_overflow} !== {e.pend, e.req, e.urg, e.ovf}) begin
                n_err++;
                $display("FAIL saturate edge%0d: got pend=%0d req=%b urg=%b ovf=%b, need pend=%0d req=%b urg=%b ovf=%b",
                         c, ref_pending, refresh_req, ref_urgent, ref_overflow, e.pend, e.req, e.urg, e.ovf);
            end
            if (c == 127 || c == 128 || c == 143 || c == 144) begin
                n_cmp++;
                if (ref_urgent !== (c >= 128) || ref_overflow !== (c >= 144)
                    || ref_pending !== ((c == 127) ? 4'd7 : 4'd8)) begin
                    n_err++;
                    $display("FAIL sat_edge edge%0d: got pend=%0d urg=%b ovf=%b", c, ref_pending, ref_urgent, ref_overflow);
                end
            end
        end
        for (int c = 0; c < 3; c++) begin
            drive_cycle(1'b1, 1'b1, 1'b1);
            void'(sb_q.pop_front());
        end
        n_cmp++;
        if (ref_pending !== 4'd5 || ref_overflow !== 1'b1 || ref_urgent !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_sticky: got pend=%0d ovf=%b urg=%b, need 5/1/0", ref_pending, ref_overflow, ref_urgent);
        end
    endtask

    task automatic test_coincident();
        drive_cycle(1'b0, 1'b1, 1'b0);
        void'(sb_q.pop_front());
        for (int c = 1; c <= 64; c++) begin
            drive_cycle(1'b1, 1'b1, (c == 64));
            e = sb_q.pop_front();
            n_cmp++;
            if ({ref_pending, refresh_req, ref_urgent, ref_overflow} !== {e.pend, e.req, e.urg, e.ovf}) begin
                n_err++;
                $display("FAIL coincident edge%0d: got pend=%0d req=%b urg=%b ovf=%b, need pend=%0d req=%b urg=%b ovf=%b",
                         c, ref_pending, refresh_req, ref_urgent, ref_overflow, e.pend, e.req, e.urg, e.ovf);
            end
        end
        n_cmp++;
        if (ref_pending !== 4'd3) begin
            n_err++;
            $display("FAIL tick_plus_ack: got pend=%0d, need 3", ref_pending);
        end
        drive_cycle(1'b0, 1'b1, 1'b0);
        void'(sb_q.pop_front());
        drive_cycle(1'b1, 1'b1, 1'b1);
        void'(sb_q.pop_front());
        n_cmp++;
        if (ref_pending !== 4'd0 || ref_overflow !== 1'b0 || refresh_req !== 1'b0) begin
            n_err++;
            $display("FAIL ack_at_zero: got pend=%0d ovf=%b req=%b, need 0/0/0", ref_pending, ref_overflow, refresh_req);
        end
    endtask

    task automatic test_mid_reset();
        drive_cycle(1'b0, 1'b1, 1'b0);
        void'(sb_q.pop_front());
        for (int c = 1; c <= 88; c++) begin
            drive_cycle(1'b1, 1'b1, 1'b0);
            void'(sb_q.pop_front());
        end
        n_cmp++;
        if (ref_pending !== 4'd5) begin
            n_err++;
            $display("FAIL pre_reset: got pend=%0d, need 5", ref_pending);
        end
        drive_cycle(1'b0, 1'b1, 1'b1);
        void'(sb_q.pop_front());
        n_cmp++;
        if (ref_pending !== 4'd0 || ref_overflow !== 1'b0 || refresh_req !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset: got pend=%0d ovf=%b req=%b, need 0/0/0", ref_pending, ref_overflow, refresh_req);
        end
        for (int c = 1; c <= 16; c++) begin
            drive_cycle(1'b1, 1'b1, 1'b0);
            e = sb_q.pop_front();
            n_cmp++;
            if (ref_pending !== e.pend || ref_pending !== ((c == 16) ? 4'd1 : 4'd0)) begin
                n_err++;
                $display("FAIL post_reset edge%0d: got pend=%0d, need %0d", c, ref_pending, (c == 16) ? 1 : 0);
            end
        end
    endtask

`ifdef SDR_REF_POSTPONE_EN
    task automatic test_postpone();
        state_idle = 1'b0;
        fifo_empty = 1'b0;
        drive_cycle(1'b0, 1'b1, 1'b0);
        void'(sb_q.pop_front());
        for (int c = 1; c <= 64; c++) begin
            drive_cycle(1'b1, 1'b1, 1'b0);
            e = sb_q.pop_front();
            if (c % RI == 0) begin
                n_cmp++;
                if (refresh_req !== e.req || refresh_req !== (c == 64)) begin
                    n_err++;
                    $display("FAIL postpone edge%0d: got pend=%0d req=%b, need req=%b",
                             c, ref_pending, refresh_req, (c == 64));
                end
            end
            if (c == 32) begin
                state_idle = 1'b1;
                fifo_empty = 1'b1;
                #1;
                n_cmp++;
                if (refresh_req !== 1'b1) begin
                    n_err++;
                    $display("FAIL postpone_idle: got req=%b at pend=%0d, need 1", refresh_req, ref_pending);
                end
                state_idle = 1'b0;
                fifo_empty = 1'b0;
                #1;
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_tick_timing();
        test_ack_each();
        test_saturate();
        test_coincident();
        test_mid_reset();
`ifdef SDR_REF_POSTPONE_EN
        test_postpone();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sdr_ref_ctrl.md
SDR_REF_CTRL -- requirements
Module: sdr_ref_ctrl

Interface
REQ-001 SHALL have parameter REF_INTERVAL, default 780, meaning sdram_clk cycles per refresh credit (7.8 us at 100 MHz); legal 2..65535.
REQ-002 SHALL have parameter MAX_PEND, default 8, meaning maximum outstanding refresh credits; legal 1..15.
REQ-003 SHALL have parameter LAZY_THR, default 4, meaning the credit level that forces a request in postpone mode; legal 1..MAX_PEND.
REQ-004 sdram_clk  in  1  sole clock; all logic on its rising edge.
REQ-005 sdram_rst_n  in  1  reset, synchronous, active-low.
REQ-006 ref_en  in  1  high enables the refresh interval timer.
REQ-007 cmd_aref  in  1  one-cycle refresh acknowledge from the SDRAM command FSM.
REQ-008 state_idle  in  1  high while the command FSM is idle.
REQ-009 fifo_empty  in  1  high while the ingress command FIFO is empty.
REQ-010 refresh_req  out  1  request to the command FSM to issue auto-refresh.
REQ-011 ref_urgent  out  1  high when pending credits equal MAX_PEND.
REQ-012 ref_pending  out  4  current outstanding credit count.
REQ-013 ref_overflow  out  1  sticky error: a credit was lost at saturation.

Function
REQ-014 Timer: 16-bit down-counter, loaded with REF_INTERVAL-1; decrements each cycle ref_en=1; at 0 it produces internal tick and reloads REF_INTERVAL-1 on the same edge.
REQ-015 ref_en=0: timer loads REF_INTERVAL-1 every cycle, no tick; pending count held.
REQ-016 First tick SHALL occur REF_INTERVAL cycles after ref_en rises (or reset releases with ref_en=1); subsequent ticks every REF_INTERVAL cycles.
REQ-017 Pending update per edge: tick only -> +1; cmd_aref only -> -1; both -> unchanged; neither -> unchanged.
REQ-018 tick with pending==MAX_PEND and no cmd_aref: pending stays MAX_PEND, ref_overflow set to 1 and held until reset.
REQ-019 cmd_aref with pending==0 (e.g., init-sequence refreshes): ignored, pending stays 0, no error.
REQ-020 ref_pending SHALL be the registered count; refresh_req and ref_urgent are combinational decodes of it (plus state_idle/fifo_empty per REQ-025), so refresh_req drops in the cycle after the acknowledging edge.
REQ-021 ref_urgent = (pending == MAX_PEND).
REQ-022 No further state machine beyond the counter and timer; behaviour is fully defined by REQ-014..REQ-021.

Reset
REQ-023 sdram_rst_n=0 at an edge SHALL set timer=REF_INTERVAL-1, pending=0, ref_overflow=0; hence refresh_req=0, ref_urgent=0, ref_pending=0.
REQ-024 Reset mid-operation SHALL discard all outstanding credits and the partial interval; any cmd_aref sampled with reset is ignored.

Configuration
REQ-025 Macro SDR_REF_POSTPONE_EN defined: refresh_req = (pending >= LAZY_THR) | (pending != 0 & state_idle & fifo_empty), i.e., refresh is deferred while traffic is queued unless credits reach LAZY_THR.
REQ-026 Macro SDR_REF_POSTPONE_EN undefined: refresh_req = (pending != 0); LAZY_THR, state_idle and fifo_empty are unused.

Verification (bench parameters REF_INTERVAL=16, MAX_PEND=8, LAZY_THR=4)
REQ-027 Reset release with ref_en=1, no acks -> ref_pending 1 after edge 16, 2 after edge 32; refresh_req=1 from edge 16 (macro undefined).
REQ-028 ref_en=1, ack each credit 3 cycles after it appears -> ref_pending alternates 1/0, refresh_req drops one cycle after each cmd_aref, ref_overflow=0.
REQ-029 No acks for 9 intervals -> ref_pending saturates at 8, ref_urgent=1 from edge 128, ref_overflow=1 at edge 144 and stays 1 after later acks until reset.
REQ-030 pending=3, cmd_aref coincident with tick -> ref_pending remains 3; cmd_aref at pending=0 -> stays 0, ref_overflow unchanged.
REQ-031 SDR_REF_POSTPONE_EN defined, fifo_empty=0, state_idle=0 -> refresh_req=0 at pending 1..3, 1 at pending 4; at pending 2, fifo_empty=1 & state_idle=1 -> refresh_req=1 combinationally.
REQ-032 pending=5, sdram_rst_n=0 one cycle -> ref_pending=0, ref_overflow=0, next tick 16 cycles after release.
